// File: rtl/mul_special_pipe.sv
// rtl/mul_special_pipe.sv - pipelined special-operand classifier and special-result generator for the FP multiplier
module mul_special_pipe #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int LANES  = 1,
  parameter int DAZ    = 0,
  parameter int CNT_W  = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LANES*(SIGN_W+EXPO_W+MANT_W)-1:0] a_i,
  input  logic [LANES*(SIGN_W+EXPO_W+MANT_W)-1:0] b_i,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [LANES-1:0]                        is_special_o,
  output logic [LANES*(SIGN_W+EXPO_W+MANT_W)-1:0] res_o,
  output logic [LANES-1:0]                        invalid_o,
  output logic [LANES*3-1:0]                      cls_a_o,
  output logic [LANES*3-1:0]                      cls_b_o,
  input  logic                                    flag_clr,
  output logic                                    invalid_sticky_o,
  output logic [CNT_W-1:0]                        special_cnt_o
);

  localparam int W = SIGN_W + EXPO_W + MANT_W;

  localparam logic [2:0] CLS_NORM = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_ZERO = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_QNAN = 3'd4;
  localparam logic [2:0] CLS_SNAN = 3'd5;

  localparam logic [W-1:0] QNAN_WORD = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  // Operand class from the exponent and stored mantissa fields.
  function automatic logic [2:0] classify(input logic [EXPO_W-1:0] e, input logic [MANT_W-1:0] m);
    logic [2:0] c;
    c = CLS_NORM;
    if (e == '0) begin
      c = (m == '0 || DAZ != 0) ? CLS_ZERO : CLS_SUB;
    end else if (e == '1) begin
      if (m == '0)
        c = CLS_INF;
      else if (m[MANT_W-1])
        c = CLS_QNAN;
      else
        c = CLS_SNAN;
    end
    return c;
  endfunction

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s2_adv;
  logic                 in_xfer;
  logic                 out_xfer;

  logic [LANES*3-1:0]   cls_a_d;
  logic [LANES*3-1:0]   cls_b_d;
  logic [LANES-1:0]     sgn_d;
  logic [LANES*3-1:0]   s1_cls_a;
  logic [LANES*3-1:0]   s1_cls_b;
  logic [LANES-1:0]     s1_sgn;

  logic [LANES-1:0]     spec_d;
  logic [LANES-1:0]     inv_d;
  logic [LANES*W-1:0]   res_d;
  logic [LANES-1:0]     s2_spec;
  logic [LANES-1:0]     s2_inv;
  logic [LANES*W-1:0]   s2_res;
  logic [LANES*3-1:0]   s2_cls_a;
  logic [LANES*3-1:0]   s2_cls_b;

  logic                 sticky;
  logic [CNT_W-1:0]     cnt;

  // Stage 2 may load whenever it is empty or its contents leave this cycle; stage 1 follows it.
  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_valid && out_ready;

  // Per-lane classification of the incoming operands and product sign.
  always_comb begin
    cls_a_d = '0;
    cls_b_d = '0;
    sgn_d   = '0;
    for (int k = 0; k < LANES; k++) begin
      cls_a_d[k*3 +: 3] = classify(a_i[k*W+MANT_W +: EXPO_W], a_i[k*W +: MANT_W]);
      cls_b_d[k*3 +: 3] = classify(b_i[k*W+MANT_W +: EXPO_W], b_i[k*W +: MANT_W]);
      sgn_d[k]          = a_i[k*W+W-1] ^ b_i[k*W+W-1];
    end
  end

  // Special result and invalid flag from the stage-1 classes, NaN beats Inf beats zero.
  always_comb begin
    logic [2:0] ca;
    logic [2:0] cb;
    logic       nan;
    logic       zero_inf;
    spec_d   = '0;
    inv_d    = '0;
    res_d    = '0;
    ca       = CLS_NORM;
    cb       = CLS_NORM;
    nan      = 1'b0;
    zero_inf = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      ca       = s1_cls_a[k*3 +: 3];
      cb       = s1_cls_b[k*3 +: 3];
      nan      = (ca == CLS_QNAN) || (ca == CLS_SNAN) || (cb == CLS_QNAN) || (cb == CLS_SNAN);
      zero_inf = ((ca == CLS_ZERO) && (cb == CLS_INF)) || ((ca == CLS_INF) && (cb == CLS_ZERO));
      inv_d[k] = (ca == CLS_SNAN) || (cb == CLS_SNAN) || zero_inf;
      if (nan || zero_inf) begin
        spec_d[k]         = 1'b1;
        res_d[k*W +: W]   = QNAN_WORD;
      end else if ((ca == CLS_INF) || (cb == CLS_INF)) begin
        spec_d[k]         = 1'b1;
        res_d[k*W +: W]   = {s1_sgn[k], {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
      end else if ((ca == CLS_ZERO) || (cb == CLS_ZERO)) begin
        spec_d[k]         = 1'b1;
        res_d[k*W +: W]   = {s1_sgn[k], {(EXPO_W+MANT_W){1'b0}}};
      end
    end
  end

  // Stage valid bits; reset discards whatever is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (s2_adv)
        s2_valid <= s1_valid;
    end
  end

  // Stage data registers carry no reset; outputs are masked while out_valid is low.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_cls_a <= cls_a_d;
      s1_cls_b <= cls_b_d;
      s1_sgn   <= sgn_d;
    end
    if (s2_adv) begin
      s2_spec  <= spec_d;
      s2_inv   <= inv_d;
      s2_res   <= res_d;
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
    end
  end

  // Sticky invalid and saturating special counter; a coincident transfer overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (flag_clr) begin
      sticky <= out_xfer && (|s2_inv);
      cnt    <= (out_xfer && (|s2_spec)) ? CNT_W'(1) : '0;
    end else if (out_xfer) begin
      if (|s2_inv)
        sticky <= 1'b1;
      if ((|s2_spec) && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_valid        = s2_valid;
  assign is_special_o     = s2_valid ? s2_spec  : '0;
  assign invalid_o        = s2_valid ? s2_inv   : '0;
  assign res_o            = s2_valid ? s2_res   : '0;
  assign cls_a_o          = s2_valid ? s2_cls_a : '0;
  assign cls_b_o          = s2_valid ? s2_cls_b : '0;
  assign invalid_sticky_o = sticky;
  assign special_cnt_o    = cnt;

endmodule

// File: tb/tb_mul_special_pipe.sv
// tb/tb_mul_special_pipe.sv - randomized self-checking bench for mul_special_pipe
module tb_mul_special_pipe;

  localparam int W = 32;
  localparam int L = 2;

  typedef struct {
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    int             age;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           out_ready;
  logic           flag_clr;
  logic [L*W-1:0] a_i;
  logic [L*W-1:0] b_i;

  logic           ir  [2];
  logic           ov  [2];
  logic [L-1:0]   sp  [2];
  logic [L*W-1:0] res [2];
  logic [L-1:0]   inv [2];
  logic [L*3-1:0] ca  [2];
  logic [L*3-1:0] cb  [2];
  logic           stk [2];
  logic [15:0]    cnt0;
  logic [1:0]     cnt1;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q[$];
  bit   m_stk [2];
  int   m_cnt [2];
  int   cmax  [2] = '{65535, 3};

  always #5 clk = ~clk;

  mul_special_pipe #(.LANES(L), .DAZ(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a_i(a_i), .b_i(b_i),
    .out_valid(ov[0]), .out_ready(out_ready), .is_special_o(sp[0]), .res_o(res[0]),
    .invalid_o(inv[0]), .cls_a_o(ca[0]), .cls_b_o(cb[0]), .flag_clr(flag_clr),
    .invalid_sticky_o(stk[0]), .special_cnt_o(cnt0)
  );

  mul_special_pipe #(.LANES(L), .DAZ(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a_i(a_i), .b_i(b_i),
    .out_valid(ov[1]), .out_ready(out_ready), .is_special_o(sp[1]), .res_o(res[1]),
    .invalid_o(inv[1]), .cls_a_o(ca[1]), .cls_b_o(cb[1]), .flag_clr(flag_clr),
    .invalid_sticky_o(stk[1]), .special_cnt_o(cnt1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Class number from IEEE field values.
  function automatic int cls_of(input logic [31:0] x, input bit daz);
    int e;
    int m;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 255) begin
      if (m == 0) return 3;
      if (m >= 32'h0040_0000) return 4;
      return 5;
    end
    if (e == 0) return (m == 0 || daz) ? 2 : 1;
    return 0;
  endfunction

  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input bit daz,
                                  output bit spc, output bit invl, output logic [31:0] r,
                                  output int cla, output int clb);
    bit s;
    bit nan;
    bit zi;
    s    = a[31] ^ b[31];
    cla  = cls_of(a, daz);
    clb  = cls_of(b, daz);
    nan  = (cla >= 4) || (clb >= 4);
    zi   = (cla == 2 && clb == 3) || (cla == 3 && clb == 2);
    invl = (cla == 5) || (clb == 5) || zi;
    spc  = 1'b1;
    if (nan || zi)                r = 32'h7FC0_0000;
    else if (cla == 3 || clb == 3) r = {s, 8'hFF, 23'h0};
    else if (cla == 2 || clb == 2) r = {s, 31'h0};
    else begin
      spc = 1'b0;
      r   = 32'h0;
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic sg;
    sg = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       return {sg, 31'h0};
      1:       return {sg, 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
      2:       return {sg, 8'hFF, 23'h0};
      3:       return {sg, 8'hFF, 1'b1, 22'($urandom)};
      4:       return {sg, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3F_FFFF))};
      default: return {sg, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  function automatic logic [L*W-1:0] rand_bundle();
    return {rand_op(), rand_op()};
  endfunction

  // One clock cycle: drive, check against the model at the settled point, then advance the model.
  task automatic step(input bit iv, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                      input bit ordy, input bit fclr, output bit accepted);
    bit             exp_ov;
    bit             exp_ir;
    bit             s1_occ;
    bit             out_x;
    bit             any_sp  [2];
    bit             any_inv [2];
    logic [L*W-1:0] ha;
    logic [L*W-1:0] hb;
    in_valid  = iv;
    a_i       = a;
    b_i       = b;
    out_ready = ordy;
    flag_clr  = fclr;
    #1;
    exp_ov = (q.size() > 0) && (q[0].age >= 1);
    s1_occ = (q.size() == 2) || (q.size() == 1 && q[0].age == 0);
    exp_ir = !(s1_occ && exp_ov && !ordy);
    ha = '0;
    hb = '0;
    if (q.size() > 0) begin
      ha = q[0].a;
      hb = q[0].b;
    end
    for (int d = 0; d < 2; d++) begin
      logic [L*W-1:0] e_res;
      logic [L-1:0]   e_sp;
      logic [L-1:0]   e_inv;
      logic [L*3-1:0] e_ca;
      logic [L*3-1:0] e_cb;
      bit             spc;
      bit             invl;
      logic [31:0]    r;
      int             cla;
      int             clb;
      e_res = '0; e_sp = '0; e_inv = '0; e_ca = '0; e_cb = '0;
      if (exp_ov) begin
        for (int k = 0; k < L; k++) begin
          ref_mul(ha[k*W +: W], hb[k*W +: W], d == 1, spc, invl, r, cla, clb);
          e_sp[k]         = spc;
          e_inv[k]        = invl;
          e_res[k*W +: W] = r;
          e_ca[k*3 +: 3]  = 3'(cla);
          e_cb[k*3 +: 3]  = 3'(clb);
        end
      end
      any_sp[d]  = |e_sp;
      any_inv[d] = |e_inv;
      check($sformatf("d%0d_in_ready", d),  64'(ir[d]),  64'(exp_ir));
      check($sformatf("d%0d_out_valid", d), 64'(ov[d]),  64'(exp_ov));
      check($sformatf("d%0d_is_special", d), 64'(sp[d]), 64'(e_sp));
      check($sformatf("d%0d_res", d),       64'(res[d]), 64'(e_res));
      check($sformatf("d%0d_invalid", d),   64'(inv[d]), 64'(e_inv));
      check($sformatf("d%0d_cls_a", d),     64'(ca[d]),  64'(e_ca));
      check($sformatf("d%0d_cls_b", d),     64'(cb[d]),  64'(e_cb));
      check($sformatf("d%0d_sticky", d),    64'(stk[d]), 64'(m_stk[d]));
      check($sformatf("d%0d_cnt", d), (d == 0) ? 64'(cnt0) : 64'(cnt1), 64'(m_cnt[d]));
    end
    accepted = iv && exp_ir;
    out_x    = exp_ov && ordy;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (fclr) begin
        m_stk[d] = out_x && any_inv[d];
        m_cnt[d] = (out_x && any_sp[d]) ? 1 : 0;
      end else if (out_x) begin
        if (any_inv[d]) m_stk[d] = 1'b1;
        if (any_sp[d] && m_cnt[d] < cmax[d]) m_cnt[d]++;
      end
    end
    if (out_x) void'(q.pop_front());
    foreach (q[i]) q[i].age++;
    if (accepted) q.push_back('{a, b, 0});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flag_clr = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_out_valid", d), 64'(ov[d]),  64'(0));
      check($sformatf("d%0d_rst_in_ready", d),  64'(ir[d]),  64'(1));
      check($sformatf("d%0d_rst_res", d),       64'(res[d]), 64'(0));
      check($sformatf("d%0d_rst_sticky", d),    64'(stk[d]), 64'(0));
      check($sformatf("d%0d_rst_cnt", d), (d == 0) ? 64'(cnt0) : 64'(cnt1), 64'(0));
    end
    q.delete();
    m_stk = '{1'b0, 1'b0};
    m_cnt = '{0, 0};
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, acc);
      n++;
    end
    if (q.size() > 0) check("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  logic [31:0] dir_a [7] = '{32'h7F80_0000, 32'h7F80_0001, 32'h7FC0_0000, 32'hFF80_0000,
                             32'h8000_0000, 32'h3F80_0000, 32'h0000_0001};
  logic [31:0] dir_b [7] = '{32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000,
                             32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};

  initial begin
    bit acc;
    int sent;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0; a_i = '0; b_i = '0;
    @(negedge clk);
    do_reset();

    // Directed operand pairs in lane 0, random lane 1, back to back.
    for (int i = 0; i < 7; i++)
      step(1'b1, {rand_op(), dir_a[i]}, {rand_op(), dir_b[i]}, 1'b1, 1'b0, acc);
    drain();

    // Eight bundles streamed with the output stalled on cycles 3-5.
    sent = 0;
    for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
      step(sent < 8, rand_bundle(), rand_bundle(), !(c >= 3 && c <= 5), 1'b0, acc);
      if (acc) sent++;
    end
    check("stream_sent", 64'(sent), 64'(8));
    check("stream_drained", 64'(q.size()), 64'(0));

    // Counter saturation on the narrow counter after five special transfers.
    step(1'b0, '0, '0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 5; i++)
      step(1'b1, {32'h3F80_0000, 32'hFF80_0000}, {32'h3F80_0000, 32'h4000_0000}, 1'b1, 1'b0, acc);
    drain();
    check("cnt_sat_w2", 64'(cnt1), 64'(3));
    check("cnt_w16", 64'(cnt0), 64'(5));

    // Clear coinciding with an invalid transfer: the transfer wins.
    step(1'b1, {32'h3F80_0000, 32'h7F80_0000}, {32'h3F80_0000, 32'h0000_0000}, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b1, acc);
    check("clr_win_sticky0", 64'(stk[0]), 64'(1));
    check("clr_win_cnt0", 64'(cnt0), 64'(1));
    check("clr_win_sticky1", 64'(stk[1]), 64'(1));
    check("clr_win_cnt1", 64'(cnt1), 64'(1));

    // Reset asserted mid-stream.
    for (int i = 0; i < 3; i++)
      step(1'b1, rand_bundle(), rand_bundle(), 1'b0, 1'b0, acc);
    do_reset();

    // Random traffic, back-pressure and clears.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_bundle(), rand_bundle(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
